// File: rtl/add32_seq.sv
// -----------------------------------------------------------------------------
// add32_seq -- 32-bit add/subtract unit built around one 16-bit carry-lookahead
// adder cell that is time-shared across the low and high halves of the word.
//
// One operation takes four cycles: IDLE (accept) -> LO -> HI -> DONE.
//
// Ports:
//   clk     in   1   single clock, rising edge
//   clr_n   in   1   asynchronous active-low reset
//   start   in   1   request an operation (sampled only in IDLE)
//   sub     in   1   0 = a + b, 1 = a - b (sampled with start)
//   a       in  32   operand A (sampled with start)
//   b       in  32   operand B (sampled with start)
//   ready   out  1   high only in IDLE
//   done    out  1   one-cycle pulse while the result is valid
//   result  out 32   registered sum / difference
//   c_out   out  1   carry out of bit 31 (for sub: 1 = no borrow)
//   ovf     out  1   two's-complement signed overflow
//   zero    out  1   result == 0
// -----------------------------------------------------------------------------

// 16-bit carry-lookahead adder cell: four 4-bit groups with in-group lookahead
// and a second lookahead level across the group generate/propagate terms.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    // NOTE: every variable written in an always_comb gets a value on every
    // path (here by being computed unconditionally); a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        p = a ^ b;
        g = a & b;

        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        // Group-level lookahead: each group carry-in is a flat function of c_in.
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_in);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

        // In-group lookahead from each group's carry-in.
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end

        sum   = p ^ c;
        c_out = gc[4];
    end
endmodule

module add32_seq (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        c_out,
    output logic        ovf,
    output logic        zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] op_a;      // latched operand A
    logic [31:0] op_b;      // latched operand B, already inverted for subtract
    logic        op_sub;    // latched sub, used as the low-half carry-in
    logic        carry;     // carry from the low half into the high half

    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LO;
            LO:      state_next = HI;
            HI:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // ---------------- shared adder ----------------
    // The low half is only added in LO; every other state presents the high
    // half, which is what HI consumes. The carry-in for the low half is the
    // latched sub bit, so no carry from a previous operation can leak in.
    always_comb begin
        add_a   = op_a[31:16];
        add_b   = op_b[31:16];
        add_cin = carry;
        if (state == LO) begin
            add_a   = op_a[15:0];
            add_b   = op_b[15:0];
            add_cin = op_sub;
        end
    end

    cla16 u_cla16 (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // ---------------- datapath registers ----------------
    // NOTE: the operand and carry registers are reset along with the outputs
    // so an aborted operation leaves no stale data behind; they are a handful
    // of flops, not a memory array, so the reset costs nothing meaningful.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            carry  <= 1'b0;
            result <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= sub ? ~b : b;
                        op_sub <= sub;
                    end
                end
                LO: begin
                    result[15:0] <= add_sum;
                    carry        <= add_cout;
                end
                HI: begin
                    result[31:16] <= add_sum;
                    c_out         <= add_cout;
                    ovf           <= (op_a[31] == op_b[31]) && (add_sum[15] != op_a[31]);
                    zero          <= (add_sum == 16'h0000) && (result[15:0] == 16'h0000);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add32_seq.sv
// -----------------------------------------------------------------------------
// tb_add32_seq -- directed self-checking bench for add32_seq.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the rising edge the DUT acts on.
// -----------------------------------------------------------------------------
module tb_add32_seq;
    logic        clk;
    logic        clr_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int vectors;
    int miscompares;

    add32_seq dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait for done. latency is the number of falling
    // edges from the accept edge to the one where done is seen, or -1 when a
    // wait bound expires.
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic op_sub, output int latency);
        int n;
        latency = -1;
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!ready) return;
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = ~op_a;
        b     = ~op_b;
        sub   = ~op_sub;
        for (int i = 1; i <= 10; i++) begin
            if (done) begin
                latency = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", ready);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got %b want 0", done);
        end
        vectors++;
        if ({result, c_out, ovf, zero} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got result=%h c=%b v=%b z=%b want all 0",
                     result, c_out, ovf, zero);
        end
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        int lat;
        do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL add_basic_latency got %0d want 3", lat);
        end
        vectors++;
        if (result !== 32'h0001_0000) begin
            miscompares++;
            $display("FAIL add_basic_result got %h want 00010000", result);
        end
        vectors++;
        if ({c_out, ovf, zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL add_basic_flags got c=%b v=%b z=%b want 0 0 0", c_out, ovf, zero);
        end
        // One cycle later: done gone, back in IDLE, result held.
        @(negedge clk);
        vectors++;
        if ({done, ready} !== 2'b01 || result !== 32'h0001_0000) begin
            miscompares++;
            $display("FAIL add_basic_hold got done=%b ready=%b result=%h want 0 1 00010000",
                     done, ready, result);
        end
    endtask

    task automatic test_carry_wrap();
        int lat;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        vectors++;
        if (lat !== 3 || result !== 32'h0000_0000 || {c_out, ovf, zero} !== 3'b101) begin
            miscompares++;
            $display("FAIL carry_wrap got lat=%0d result=%h c=%b v=%b z=%b want 3 00000000 1 0 1",
                     lat, result, c_out, ovf, zero);
        end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        vectors++;
        if (lat !== 3 || result !== 32'h8000_0000 || {c_out, ovf, zero} !== 3'b010) begin
            miscompares++;
            $display("FAIL ovf_add got lat=%0d result=%h c=%b v=%b z=%b want 3 80000000 0 1 0",
                     lat, result, c_out, ovf, zero);
        end
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
        vectors++;
        if (lat !== 3 || result !== 32'h7FFF_FFFF || {c_out, ovf, zero} !== 3'b110) begin
            miscompares++;
            $display("FAIL ovf_sub got lat=%0d result=%h c=%b v=%b z=%b want 3 7fffffff 1 1 0",
                     lat, result, c_out, ovf, zero);
        end
    endtask

    task automatic test_sub();
        int lat;
        do_op(32'd5, 32'd7, 1'b1, lat);
        vectors++;
        if (lat !== 3 || result !== 32'hFFFF_FFFE || {c_out, ovf, zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL sub_borrow got lat=%0d result=%h c=%b v=%b z=%b want 3 fffffffe 0 0 0",
                     lat, result, c_out, ovf, zero);
        end
        do_op(32'd7, 32'd5, 1'b1, lat);
        vectors++;
        if (lat !== 3 || result !== 32'h0000_0002 || {c_out, ovf, zero} !== 3'b100) begin
            miscompares++;
            $display("FAIL sub_noborrow got lat=%0d result=%h c=%b v=%b z=%b want 3 00000002 1 0 0",
                     lat, result, c_out, ovf, zero);
        end
    endtask

    // start held high for 16 cycles while a/b/sub change every cycle. Only the
    // operands present at every 4th falling edge (just before an IDLE rising
    // edge) may be used; the values in between are decoys.
    task automatic test_back_to_back();
        logic [31:0] va  [4];
        logic [31:0] vb  [4];
        logic        vs  [4];
        logic [31:0] er  [4];
        logic [2:0]  ef  [4];  // {c_out, ovf, zero}
        va[0] = 32'h1234_5678; vb[0] = 32'h1111_1111; vs[0] = 1'b0; er[0] = 32'h2345_6789; ef[0] = 3'b000;
        va[1] = 32'h0000_0010; vb[1] = 32'h0000_0010; vs[1] = 1'b1; er[1] = 32'h0000_0000; ef[1] = 3'b101;
        va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vs[2] = 1'b0; er[2] = 32'h0000_0000; ef[2] = 3'b111;
        va[3] = 32'h0001_0000; vb[3] = 32'h0000_0001; vs[3] = 1'b1; er[3] = 32'h0000_FFFF; ef[3] = 3'b100;

        for (int n = 0; n < 16; n++) begin
            vectors++;
            if (ready !== (n % 4 == 0) || done !== (n % 4 == 3)) begin
                miscompares++;
                $display("FAIL b2b_handshake cycle %0d got ready=%b done=%b want %b %b",
                         n, ready, done, (n % 4 == 0), (n % 4 == 3));
            end
            if (n % 4 == 3) begin
                vectors++;
                if (result !== er[n/4] || {c_out, ovf, zero} !== ef[n/4]) begin
                    miscompares++;
                    $display("FAIL b2b_result op %0d got result=%h flags=%b want %h %b",
                             n / 4, result, {c_out, ovf, zero}, er[n/4], ef[n/4]);
                end
            end
            start = 1'b1;
            if (n % 4 == 0) begin
                a   = va[n/4];
                b   = vb[n/4];
                sub = vs[n/4];
            end else begin
                a   = 32'hDEAD_0000 | n;
                b   = 32'h0BAD_F00D ^ n;
                sub = ~vs[n/4];
            end
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end got ready=%b done=%b want 1 0", ready, done);
        end
    endtask

    // Reset pulsed while the operation is in HI: outputs clear immediately,
    // no done follows, and the next operation runs normally.
    task automatic test_reset_mid_op();
        int lat;
        int seen_done;
        a     = 32'h0F0F_0F0F;
        b     = 32'h0101_0101;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);          // accept
        @(negedge clk);          // LO
        start = 1'b0;
        @(negedge clk);          // HI
        vectors++;
        if (ready !== 1'b0 || result[15:0] !== 16'h1010) begin
            miscompares++;
            $display("FAIL rst_mid_pre got ready=%b result_lo=%h want 0 1010", ready, result[15:0]);
        end
        #1 clr_n = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || {result, c_out, ovf, zero} !== 35'h0) begin
            miscompares++;
            $display("FAIL rst_mid_clear got ready=%b done=%b result=%h c=%b v=%b z=%b want 1 0 0 0 0 0",
                     ready, done, result, c_out, ovf, zero);
        end
        @(negedge clk);
        clr_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_nodone got %0d done cycles want 0", seen_done);
        end
        do_op(32'hFFFF_0000, 32'h0001_0000, 1'b0, lat);
        vectors++;
        if (lat !== 3 || result !== 32'h0000_0000 || {c_out, ovf, zero} !== 3'b101) begin
            miscompares++;
            $display("FAIL rst_mid_next got lat=%0d result=%h c=%b v=%b z=%b want 3 00000000 1 0 1",
                     lat, result, c_out, ovf, zero);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        @(negedge clk);
        test_reset();
        test_add_basic();
        test_carry_wrap();
        test_overflow();
        test_sub();
        @(negedge clk);
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
